or1k_branch_resolve_tracker: RTL and testbench

Execute-stage companion to the branch predictor. It captures each conditional branch (l.bf/l.bnf) and its predicted flag as the branch leaves decode. It resolves the branch once the SR[F] flag is valid, signals mispredicts, and drives the execute_op_bf/bnf, prev_op_brcond and flag inputs of the saturation-counter predictor. It sits between the decode stage and the predictor update and fetch-redirect logic.

---
 rtl/or1k_branch_pkg.sv | 21 ++
 rtl/or1k_sat_counter.sv | 34 +++
 rtl/or1k_branch_resolve_tracker.sv | 173 +++++++++++++++++
 tb/tb_or1k_branch_resolve_tracker.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/or1k_branch_pkg.sv
// Shared types and helpers for the execute-stage conditional branch tracker.
// Statistics counters are built only when OR1K_BRANCH_STATS_EN is defined.
package or1k_branch_pkg;

    typedef enum logic [1:0] {
        BR_EMPTY    = 2'd0,
        BR_PENDING  = 2'd1,
        BR_RESOLVED = 2'd2
    } br_state_t;

    localparam int STAT_WIDTH_DEF = 32;

    function automatic logic br_taken(
        input logic is_bf,
        input logic is_bnf,
        input logic flag
    );
        return (is_bf && flag) || (is_bnf && !flag);
    endfunction

endpackage

// File: rtl/or1k_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Clears on synchronous active-high reset.
module or1k_sat_counter
    import or1k_branch_pkg::*;
#(
    parameter int STAT_WIDTH = STAT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc_i,
    output logic [STAT_WIDTH-1:0] count_o
);

    logic [STAT_WIDTH-1:0] count_q;
    logic [STAT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {STAT_WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/or1k_branch_resolve_tracker.sv
// Execute-slot tracker for l.bf/l.bnf: resolves on SR[F], flags mispredicts.
// Optional statistics counters under OR1K_BRANCH_STATS_EN.
module or1k_branch_resolve_tracker
    import or1k_branch_pkg::*;
#(
    parameter int STAT_WIDTH = STAT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  padv_decode_i,
    input  logic                  pipeline_flush_i,
    input  logic                  decode_op_bf_i,
    input  logic                  decode_op_bnf_i,
    input  logic                  decode_predicted_flag_i,
    input  logic                  flag_i,
    input  logic                  flag_valid_i,
    output logic                  execute_op_bf_o,
    output logic                  execute_op_bnf_o,
    output logic                  prev_op_brcond_o,
    output logic                  resolved_flag_o,
    output logic                  resolve_stall_o,
    output logic                  branch_mispredict_o,
    output logic [STAT_WIDTH-1:0] branch_count_o,
    output logic [STAT_WIDTH-1:0] mispredict_count_o
);

    br_state_t state_q;
    br_state_t state_d;

    logic is_bf_q, is_bf_d;
    logic is_bnf_q, is_bnf_d;
    logic pred_flag_q, pred_flag_d;
    logic res_flag_q, res_flag_d;
    logic mis_q, mis_d;
    logic res_pulse_q, res_pulse_d;

    logic is_branch;
    logic pending;
    logic stall;
    logic resolve;
    logic advance;
    logic mis_now;

    always_comb begin
        is_branch = decode_op_bf_i || decode_op_bnf_i;
        pending   = (state_q == BR_PENDING);
        stall     = pending && !flag_valid_i;
        resolve   = pending && flag_valid_i;
        // decode advance during a stall is ignored
        advance   = padv_decode_i && !stall;
        mis_now   = br_taken(is_bf_q, is_bnf_q, flag_i) != pred_flag_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BR_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (pipeline_flush_i) begin
            state_d = BR_EMPTY;
        end else if (advance && is_branch) begin
            state_d = BR_PENDING;
        end else if (advance) begin
            state_d = BR_EMPTY;
        end else if (resolve) begin
            state_d = BR_RESOLVED;
        end
    end

    always_comb begin
        is_bf_d     = is_bf_q;
        is_bnf_d    = is_bnf_q;
        pred_flag_d = pred_flag_q;
        res_flag_d  = res_flag_q;
        mis_d       = mis_q;
        res_pulse_d = 1'b0;
        if (pipeline_flush_i) begin
            is_bf_d     = 1'b0;
            is_bnf_d    = 1'b0;
            pred_flag_d = 1'b0;
            res_flag_d  = 1'b0;
            mis_d       = 1'b0;
        end else begin
            if (resolve) begin
                res_flag_d  = flag_i;
                mis_d       = mis_now;
                res_pulse_d = 1'b1;
            end
            if (advance && is_branch) begin
                is_bf_d     = decode_op_bf_i;
                is_bnf_d    = decode_op_bnf_i;
                pred_flag_d = decode_predicted_flag_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_bf_q     <= 1'b0;
            is_bnf_q    <= 1'b0;
            pred_flag_q <= 1'b0;
            res_flag_q  <= 1'b0;
            mis_q       <= 1'b0;
            res_pulse_q <= 1'b0;
        end else begin
            is_bf_q     <= is_bf_d;
            is_bnf_q    <= is_bnf_d;
            pred_flag_q <= pred_flag_d;
            res_flag_q  <= res_flag_d;
            mis_q       <= mis_d;
            res_pulse_q <= res_pulse_d;
        end
    end

    always_comb begin
        prev_op_brcond_o    = (state_q != BR_EMPTY);
        execute_op_bf_o     = prev_op_brcond_o && is_bf_q;
        execute_op_bnf_o    = prev_op_brcond_o && is_bnf_q;
        resolve_stall_o     = stall;
        // pulse lasts only the cycle after resolution
        branch_mispredict_o = res_pulse_q && mis_q;
        unique case (state_q)
            BR_PENDING:  resolved_flag_o = flag_i;
            BR_RESOLVED: resolved_flag_o = res_flag_q;
            default:     resolved_flag_o = 1'b0;
        endcase
    end

`ifdef OR1K_BRANCH_STATS_EN
    logic inc_branch;
    logic inc_mis;

    assign inc_branch = resolve && !pipeline_flush_i;
    assign inc_mis    = inc_branch && mis_now;

    or1k_sat_counter #(
        .STAT_WIDTH(STAT_WIDTH)
    ) u_branch_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (inc_branch),
        .count_o(branch_count_o)
    );

    or1k_sat_counter #(
        .STAT_WIDTH(STAT_WIDTH)
    ) u_mis_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (inc_mis),
        .count_o(mispredict_count_o)
    );
`else
    assign branch_count_o     = {STAT_WIDTH{1'b0}};
    assign mispredict_count_o = {STAT_WIDTH{1'b0}};
`endif

    a_no_adv_on_stall: assert property (
        @(posedge clk) disable iff (rst)
        !(padv_decode_i && resolve_stall_o)
    );

    a_bf_bnf_onehot: assert property (
        @(posedge clk) disable iff (rst)
        !(decode_op_bf_i && decode_op_bnf_i)
    );

endmodule

// File: tb/tb_or1k_branch_resolve_tracker.sv
// Bench for or1k_branch_resolve_tracker: directed table, corner sequences
// and random traffic against a slot-level reference model.
module tb_or1k_branch_resolve_tracker;

    localparam int SW   = 4;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    logic rst;
    logic padv, flush, bf, bnf, pred, flag, fv;
    logic ebf_o, ebnf_o, prev_o, rflag_o, stall_o, mis_o;
    logic [SW-1:0] bcnt_o, mcnt_o;

    int checks = 0;
    int errors = 0;

    bit m_full, m_done, m_bf, m_bnf, m_pred, m_res, m_pulse;
    int m_bcnt, m_mcnt;

    typedef struct {
        logic [6:0] in;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[23];

    always #5 clk = ~clk;

    or1k_branch_resolve_tracker #(
        .STAT_WIDTH(SW)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .padv_decode_i          (padv),
        .pipeline_flush_i       (flush),
        .decode_op_bf_i         (bf),
        .decode_op_bnf_i        (bnf),
        .decode_predicted_flag_i(pred),
        .flag_i                 (flag),
        .flag_valid_i           (fv),
        .execute_op_bf_o        (ebf_o),
        .execute_op_bnf_o       (ebnf_o),
        .prev_op_brcond_o       (prev_o),
        .resolved_flag_o        (rflag_o),
        .resolve_stall_o        (stall_o),
        .branch_mispredict_o    (mis_o),
        .branch_count_o         (bcnt_o),
        .mispredict_count_o     (mcnt_o)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_full = 0; m_done = 0; m_bf = 0; m_bnf = 0;
        m_pred = 0; m_res = 0; m_pulse = 0;
        m_bcnt = 0; m_mcnt = 0;
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // advance the reference slot by one clock edge
    task automatic model_step();
        bit nxt_pulse;
        bit went;
        nxt_pulse = 0;
        if (rst) begin
            model_clear();
            return;
        end
        if (flush) begin
            m_full = 0; m_done = 0; m_bf = 0; m_bnf = 0;
            m_pred = 0; m_res = 0; m_pulse = 0;
            return;
        end
        if (m_full && !m_done && !fv) begin
            m_pulse = 0;
            return;
        end
        if (m_full && !m_done) begin
            went = (m_bf && flag) || (m_bnf && !flag);
            m_done = 1;
            m_res = flag;
            m_bcnt = sat(m_bcnt + 1);
            if (went != m_pred) begin
                m_mcnt = sat(m_mcnt + 1);
                nxt_pulse = 1;
            end
        end
        if (padv) begin
            if (bf || bnf) begin
                m_full = 1; m_done = 0;
                m_bf = bf; m_bnf = bnf; m_pred = pred;
            end else begin
                m_full = 0; m_done = 0;
            end
        end
        m_pulse = nxt_pulse;
    endtask

    task automatic check_model();
        logic e_rf;
        int eb, em;
        e_rf = !m_full ? 1'b0 : (m_done ? m_res : flag);
`ifdef OR1K_BRANCH_STATS_EN
        eb = m_bcnt; em = m_mcnt;
`else
        eb = 0; em = 0;
`endif
        chk("stall", stall_o, m_full && !m_done && !fv);
        chk("prev_brcond", prev_o, m_full);
        chk("exec_bf", ebf_o, m_full && m_bf);
        chk("exec_bnf", ebnf_o, m_full && m_bnf);
        chk("resolved_flag", rflag_o, e_rf);
        chk("mispredict", mis_o, m_pulse);
        chk("branch_count", bcnt_o, eb);
        chk("mis_count", mcnt_o, em);
    endtask

    task automatic drive(input logic [6:0] v);
        {padv, flush, bf, bnf, pred, flag, fv} = v;
    endtask

    task automatic run_cycle(input logic [6:0] v);
        drive(v);
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run_row(input vec_t r, input int idx);
        string nm;
        drive(r.in);
        @(negedge clk);
        nm = $sformatf("row%0d", idx);
        chk(nm, {stall_o, prev_o, ebf_o, ebnf_o, rflag_o, mis_o}, r.exp);
        check_model();
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic vec_t mk(input logic [6:0] i, input logic [5:0] e);
        vec_t r;
        r.in = i;
        r.exp = e;
        return r;
    endfunction

    initial begin
        int pulses;
        int exp_sat;
        // in: padv,flush,bf,bnf,pred,flag,fv
        // exp: stall,prev,ebf,ebnf,rflag,mis
        tbl[0]  = mk(7'b1010111, 6'b000000);
        tbl[1]  = mk(7'b0000011, 6'b011010);
        tbl[2]  = mk(7'b0000001, 6'b011010);
        tbl[3]  = mk(7'b1001101, 6'b011010);
        tbl[4]  = mk(7'b0000011, 6'b010110);
        tbl[5]  = mk(7'b0000001, 6'b010111);
        tbl[6]  = mk(7'b0000001, 6'b010110);
        tbl[7]  = mk(7'b1010001, 6'b010110);
        tbl[8]  = mk(7'b0000010, 6'b111010);
        tbl[9]  = mk(7'b0000000, 6'b111000);
        tbl[10] = mk(7'b0000010, 6'b111010);
        tbl[11] = mk(7'b0000001, 6'b011000);
        tbl[12] = mk(7'b0000010, 6'b011000);
        tbl[13] = mk(7'b1001000, 6'b011000);
        tbl[14] = mk(7'b0100001, 6'b010100);
        tbl[15] = mk(7'b0000001, 6'b000000);
        tbl[16] = mk(7'b0000000, 6'b000000);
        tbl[17] = mk(7'b1010101, 6'b000000);
        tbl[18] = mk(7'b1010011, 6'b011010);
        tbl[19] = mk(7'b0000000, 6'b111000);
        tbl[20] = mk(7'b0000011, 6'b011010);
        tbl[21] = mk(7'b0100001, 6'b011011);
        tbl[22] = mk(7'b0000000, 6'b000000);

        rst = 1'b1;
        drive(7'b0);
        repeat (2) @(posedge clk);
        model_clear();
        #1;
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            run_row(tbl[i], i);
        end

        // reset while a branch is pending
        run_cycle(7'b1010100);
        rst = 1'b1;
        run_cycle(7'b0000000);
        rst = 1'b0;
        run_cycle(7'b0000000);
        chk("rst_prev", prev_o, 1'b0);
        chk("rst_bcnt", bcnt_o, 0);
        chk("rst_mis", mis_o, 1'b0);

        // 20 mispredicts must saturate the counter
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            run_cycle(7'b1001111);
            pulses += int'(mis_o);
            run_cycle(7'b0000011);
            pulses += int'(mis_o);
        end
        run_cycle(7'b0000000);
        pulses += int'(mis_o);
        chk("sat_pulses", pulses, 20);
`ifdef OR1K_BRANCH_STATS_EN
        exp_sat = 15;
`else
        exp_sat = 0;
`endif
        chk("sat_mis_count", mcnt_o, exp_sat);
        chk("sat_br_count", bcnt_o, exp_sat);

        rst = 1'b1;
        run_cycle(7'b0000000);
        rst = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            logic [6:0] v;
            logic k_bf, k_bnf, k_fv, k_pa;
            k_fv = ($urandom_range(3) != 0);
            k_pa = ($urandom_range(1) != 0);
            if (m_full && !m_done && !k_fv) k_pa = 1'b0;
            k_bf = 1'b0;
            k_bnf = 1'b0;
            case ($urandom_range(2))
                0: k_bf = 1'b1;
                1: k_bnf = 1'b1;
                default: ;
            endcase
            v = {k_pa, ($urandom_range(15) == 0), k_bf, k_bnf,
                 1'($urandom_range(1)), 1'($urandom_range(1)), k_fv};
            rst = ($urandom_range(199) == 0);
            run_cycle(v);
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
